vote_result_reporter: RTL and testbench
=======================================

Name: vote_result_reporter

Overview:
- Downstream stage of voting_machine.
- Monitors the live tallies (votes0/votes1) and vote_done pulses while the poll is open.
- On a close command it freezes a snapshot, decides winner/tie/margin, and cross-checks its own vote_done count against the tallies.
- Streams a 4-byte result record over a valid/ready byte interface to the display/log stage.

Parameters:
- CW, 8, width of each candidate tally input (matches votes0/votes1).
- SETTLE_CYCLES, 2, cycles waited after close_poll before sampling tallies (range 1..15).
- HEADER, 8'hA5, first byte of every result record.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- votes0  in  CW  candidate-0 tally from voting_machine.
- votes1  in  CW  candidate-1 tally from voting_machine.
- vote_done  in  1  one-cycle pulse per accepted vote from voting_machine.
- close_poll  in  1  level/pulse request to end the poll; sampled in OPEN only.
- tx_ready  in  1  downstream ready for tx_data.
- poll_open  out  1  high in OPEN state.
- tx_valid  out  1  tx_data valid.
- tx_data  out  8  result record byte.
- winner  out  1  0 = candidate 0 leads, 1 = candidate 1 leads; 0 on tie.
- tie  out  1  tallies equal at snapshot.
- margin  out  CW  |votes0 - votes1| at snapshot.
- audit_error  out  1  internal pulse count != votes0+votes1 at snapshot.
- result_valid  out  1  snapshot outputs valid; held until reset.

Behaviour:
- Reset (sync, active-high, priority over everything):
  - state = OPEN; poll_open = 1.
  - tx_valid = 0, tx_data = 0, winner = 0, tie = 0, margin = 0, audit_error = 0, result_valid = 0.
  - Internal pulse counter = 0; late_vote = 0; settle counter = 0.
  - Reset mid-transmission aborts the record; no partial byte is held.
- Pulse counter: CW+1 bits; increments on vote_done in OPEN and SETTLE; saturates at all-ones and sets sat flag (sticky until reset).
- FSM states:
  - OPEN: if close_poll = 1, go to SETTLE next cycle and clear poll_open that same edge. A vote_done coincident with close_poll is still counted.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SNAP.
  - SNAP (1 cycle):
    - Register votes0, votes1, and sum = votes0 + votes1 (CW+1 bits, no overflow).
    - winner = (votes1 > votes0).
    - tie = (votes0 == votes1).
    - margin = larger − smaller.
    - audit_error = (counter != sum).
    - result_valid = 1 at the end of this cycle.
    - Go to SEND.
  - SEND: four bytes in order: HEADER, votes0 snapshot, votes1 snapshot, status.
    - tx_valid is high throughout SEND.
    - tx_data is stable while tx_valid = 1 and tx_ready = 0.
    - A byte advances on a cycle with tx_valid & tx_ready.
    - After byte 3 is accepted, tx_valid drops the next cycle and the FSM goes to DONE.
    - tx_ready is ignored when tx_valid = 0.
  - DONE: terminal. Outputs are held; only reset leaves this state.
- Status byte:
  - bit0 = winner, bit1 = tie, bit2 = audit_error, bit3 = late_vote, bit4 = sat.
  - bits7:5 = 0.
  - late_vote is sampled when the status byte is first presented.
- late_vote: set by vote_done in SNAP, SEND, or DONE. Sticky until reset. The pulse is not counted.
- close_poll outside OPEN: ignored.
- Worst-case latency from close_poll to first tx_valid = SETTLE_CYCLES + 2 cycles.

Test Plan:
1. Reset, then vote_done ×2 with votes0 = 1, votes1 = 1, then close_poll (SETTLE_CYCLES = 2), tx_ready = 1 -> tie = 1, winner = 0, margin = 0, audit_error = 0; bytes A5, 01, 01, 02; tx_valid high exactly 4 cycles.
2. 3 pulses, votes0 = 1, votes1 = 2, close -> winner = 1, margin = 1; status = 01; first tx_valid 4 cycles after close_poll.
3. 2 pulses but votes0 = 3, votes1 = 0 -> audit_error = 1; status = 04; margin = 3, winner = 0.
4. tx_ready toggling 1,0,0,1,0,1,1 during SEND -> each byte held stable while stalled; exactly 4 transfers; order A5, v0, v1, status.
5. vote_done pulse during SEND before the status byte is presented -> status bit3 = 1; internal counter unchanged; audit result unaffected.
6. Reset asserted during byte 2 of SEND -> next cycle tx_valid = 0, result_valid = 0, poll_open = 1; a new poll runs cleanly afterward.

Source files
------------

// File: rtl/vote_result_reporter.sv
// Result reporter downstream of voting_machine: audits vote_done pulses against the
// live tallies, snapshots them on poll close and streams a 4-byte record (header, v0, v1, status).
module vote_result_reporter #(
    parameter int         CW            = 8,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] HEADER        = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] votes0,
    input  logic [CW-1:0] votes1,
    input  logic          vote_done,
    input  logic          close_poll,
    input  logic          tx_ready,
    output logic          poll_open,
    output logic          tx_valid,
    output logic [7:0]    tx_data,
    output logic          winner,
    output logic          tie,
    output logic [CW-1:0] margin,
    output logic          audit_error,
    output logic          result_valid
);

    typedef enum logic [2:0] {
        S_OPEN   = 3'd0,
        S_SETTLE = 3'd1,
        S_SNAP   = 3'd2,
        S_SEND   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW:0]   pulse_cnt;
    logic          sat;
    logic          late_vote;
    logic [3:0]    settle_cnt;
    logic [1:0]    byte_idx;
    logic [CW-1:0] v0_snap, v1_snap;
    logic [CW:0]   tally_sum;
    logic          accept;
    logic          settle_last;
    logic          counting;
    logic          late_pulse;

    function automatic logic [CW:0] sat_inc(input logic [CW:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic signed [CW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[CW] ? CW'(-d) : d[CW-1:0];
    endfunction

    function automatic logic [7:0] status_byte(input logic w, input logic t, input logic a,
                                               input logic l, input logic s);
        return {3'b000, s, l, a, t, w};
    endfunction

    assign accept      = tx_valid & tx_ready;
    assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
    assign counting    = vote_done && (state == S_OPEN || state == S_SETTLE);
    assign late_pulse  = vote_done && (state == S_SNAP || state == S_SEND || state == S_DONE);
    assign tally_sum   = {1'b0, votes0} + {1'b0, votes1};
    assign poll_open   = (state == S_OPEN);

    always_ff @(posedge clk) begin
        if (reset) state <= S_OPEN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OPEN:   if (close_poll) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_last) state_nxt = S_SNAP;
            S_SNAP:   state_nxt = S_SEND;
            S_SEND:   if (accept && byte_idx == 2'd3) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt    <= '0;
            sat          <= 1'b0;
            late_vote    <= 1'b0;
            settle_cnt   <= '0;
            byte_idx     <= '0;
            v0_snap      <= '0;
            v1_snap      <= '0;
            tx_valid     <= 1'b0;
            tx_data      <= '0;
            winner       <= 1'b0;
            tie          <= 1'b0;
            margin       <= '0;
            audit_error  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (counting) begin
                pulse_cnt <= sat_inc(pulse_cnt);
                if (&sat_inc(pulse_cnt)) sat <= 1'b1;
            end
            if (late_pulse) late_vote <= 1'b1;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 4'd1 : 4'd0;

            case (state)
                // snapshot boundary: tallies frozen, verdict and first byte registered together
                S_SNAP: begin
                    v0_snap      <= votes0;
                    v1_snap      <= votes1;
                    winner       <= (votes1 > votes0);
                    tie          <= (votes0 == votes1);
                    margin       <= abs_diff(votes0, votes1);
                    audit_error  <= (pulse_cnt != tally_sum);
                    result_valid <= 1'b1;
                    tx_valid     <= 1'b1;
                    tx_data      <= HEADER;
                    byte_idx     <= 2'd0;
                end
                // send boundary: next byte loads only on a completed handshake
                S_SEND: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    tx_data <= 8'(v0_snap);
                            2'd1:    tx_data <= 8'(v1_snap);
                            // a late pulse coinciding with this edge still makes the status
                            2'd2:    tx_data <= status_byte(winner, tie, audit_error,
                                                            late_vote | late_pulse, sat);
                            default: tx_valid <= 1'b0;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_result_reporter.sv
// Randomized + directed bench for vote_result_reporter; expected record and verdict come
// from a plain-arithmetic model of the poll (pulse count, tallies, late pulses).
module tb_vote_result_reporter;

    localparam int         CW     = 8;
    localparam int         SETTLE = 2;
    localparam logic [7:0] HDR    = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] votes0, votes1;
    logic          vote_done, close_poll, tx_ready;
    logic          poll_open, tx_valid;
    logic [7:0]    tx_data;
    logic          winner, tie;
    logic [CW-1:0] margin;
    logic          audit_error, result_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vote_result_reporter #(.CW(CW), .SETTLE_CYCLES(SETTLE), .HEADER(HDR)) dut (
        .clk(clk), .reset(reset), .votes0(votes0), .votes1(votes1),
        .vote_done(vote_done), .close_poll(close_poll), .tx_ready(tx_ready),
        .poll_open(poll_open), .tx_valid(tx_valid), .tx_data(tx_data),
        .winner(winner), .tie(tie), .margin(margin),
        .audit_error(audit_error), .result_valid(result_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_poll_open"}, poll_open, 1);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_tie"}, tie, 0);
        chk({tag, "_margin"}, margin, 0);
        chk({tag, "_audit"}, audit_error, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; vote_done = 0; close_poll = 0; tx_ready = 0;
        @(negedge clk);
        check_idle("reset");
        reset = 0;
    endtask

    // ready_mode: 0 always ready, 1 fixed stall pattern, 2 random
    // late_at: presented byte index (0..2) during which a late vote_done is injected, -1 none
    // abort_at: presented byte index at which reset is asserted, -1 none
    task automatic run_poll(input int v0, input int v1, input int npulse, input bit coinc,
                            input int ready_mode, input int late_at, input int abort_at);
        int   nopen, k, nb, cyc, cnt;
        bit   e_w, e_t, e_a, e_s, late, stalled, rdy;
        int   e_m;
        logic [7:0] exp_b, prev;
        bit   pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        cnt = (npulse > 511) ? 511 : npulse;
        e_s = (npulse >= 511);
        e_w = (v1 > v0);
        e_t = (v0 == v1);
        e_m = (v0 > v1) ? v0 - v1 : v1 - v0;
        e_a = (cnt != v0 + v1);
        late = 0;

        votes0 = CW'(v0);
        votes1 = CW'(v1);
        chk("open_before_close", poll_open, 1);

        nopen = (coinc && npulse > 0) ? npulse - 1 : npulse;
        for (int i = 0; i < nopen; i++) begin
            vote_done = 1;
            @(negedge clk);
        end
        vote_done  = coinc && npulse > 0;
        close_poll = 1;
        @(negedge clk);
        vote_done  = 0;
        close_poll = 1'($urandom_range(0, 1));
        chk("poll_open_cleared", poll_open, 0);
        chk("result_valid_settle", result_valid, 0);
        k = 1;
        while (!tx_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        close_poll = 0;
        chk("latency", k, SETTLE + 2);
        chk("result_valid", result_valid, 1);
        chk("winner", winner, e_w);
        chk("tie", tie, e_t);
        chk("margin", margin, e_m);
        chk("audit_error", audit_error, e_a);

        nb = 0; cyc = 0; stalled = 0; prev = '0;
        while (nb < 4 && cyc < 64) begin
            chk("tx_valid_send", tx_valid, 1);
            if (stalled) chk("tx_data_stable", tx_data, prev);
            if (abort_at == nb) begin
                reset = 1; tx_ready = 0; vote_done = 0;
                @(negedge clk);
                chk("abort_tx_valid", tx_valid, 0);
                chk("abort_result_valid", result_valid, 0);
                chk("abort_poll_open", poll_open, 1);
                chk("abort_tx_data", tx_data, 0);
                reset = 0;
                return;
            end
            case (nb)
                0:       exp_b = HDR;
                1:       exp_b = 8'(v0);
                2:       exp_b = 8'(v1);
                default: exp_b = {3'b000, e_s, late, e_a, e_t, e_w};
            endcase
            chk("tx_byte", tx_data, exp_b);
            case (ready_mode)
                0:       rdy = 1;
                1:       rdy = (cyc < 7) ? pat[cyc] : 1'b1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            vote_done = (late_at == nb);
            if (late_at == nb) late = 1;
            tx_ready = rdy;
            prev     = tx_data;
            stalled  = !rdy;
            if (rdy) nb++;
            cyc++;
            @(negedge clk);
        end
        vote_done = 0;
        chk("transfers", nb, 4);
        chk("tx_valid_drop", tx_valid, 0);
        if (ready_mode == 0) chk("valid_cycles", cyc, 4);
        if (ready_mode == 1) chk("valid_cycles_stall", cyc, 7);

        // terminal state ignores close_poll, tx_ready and late pulses
        close_poll = 1; tx_ready = 1; vote_done = 1;
        repeat (3) @(negedge clk);
        close_poll = 0; tx_ready = 0; vote_done = 0;
        chk("done_tx_valid", tx_valid, 0);
        chk("done_poll_open", poll_open, 0);
        chk("done_result_valid", result_valid, 1);
        chk("done_margin", margin, e_m);
        chk("done_audit", audit_error, e_a);
    endtask

    initial begin
        int v0, v1, np, lt;
        reset = 1; votes0 = '0; votes1 = '0; vote_done = 0; close_poll = 0; tx_ready = 0;
        do_reset();
        run_poll(1, 1, 2, 0, 0, -1, -1);
        do_reset();
        run_poll(1, 2, 3, 0, 0, -1, -1);
        do_reset();
        run_poll(3, 0, 2, 0, 0, -1, -1);
        do_reset();
        run_poll(5, 7, 12, 1, 1, -1, -1);
        do_reset();
        run_poll(4, 2, 6, 0, 0, 1, -1);
        do_reset();
        run_poll(9, 9, 18, 0, 0, -1, 2);
        run_poll(2, 3, 5, 0, 2, -1, -1);
        do_reset();
        run_poll(255, 255, 510, 0, 0, -1, -1);
        do_reset();
        run_poll(255, 255, 511, 0, 0, -1, -1);
        do_reset();
        run_poll(255, 0, 255, 1, 0, -1, -1);
        for (int t = 0; t < 20; t++) begin
            v0 = $urandom_range(0, 60);
            v1 = $urandom_range(0, 60);
            np = v0 + v1;
            if ($urandom_range(0, 3) == 0) begin
                if (np > 3 && $urandom_range(0, 1) == 1) np = np - $urandom_range(1, 3);
                else                                     np = np + $urandom_range(1, 3);
            end
            lt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1;
            do_reset();
            run_poll(v0, v1, np, 1'($urandom_range(0, 1)), $urandom_range(0, 2), lt, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
